tile_host_bridge: RTL and testbench



---
 rtl/tile_host_bridge_pkg.sv | 27 ++
 rtl/tile_host_bridge_if.sv | 30 +++
 rtl/tile_host_bridge_regs.sv | 169 ++++++++++++++++
 rtl/tile_host_bridge.sv | 108 ++++++++++
 tb/tb_tile_host_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_host_bridge_pkg.sv
// Shared constants for the tile host bridge: register map, STATUS bit positions
// and the bus FSM state type.
// No logic lives here; the optional IRQ_EN register address is defined
// unconditionally and only decoded when TILE_HOST_BRIDGE_IRQ_EN is defined.
package tile_host_bridge_pkg;

  // Word addresses of the register map
  localparam int unsigned ADDR_DATA_A  = 0;
  localparam int unsigned ADDR_DATA_B  = 1;
  localparam int unsigned ADDR_CSR_IN  = 2;
  localparam int unsigned ADDR_DATA_C  = 3;
  localparam int unsigned ADDR_CSR_OUT = 4;
  localparam int unsigned ADDR_STATUS  = 5;
  localparam int unsigned ADDR_IRQ_EN  = 6;

  // STATUS register bit positions
  localparam int unsigned STATUS_IN_PEND   = 0;
  localparam int unsigned STATUS_OUT_VALID = 1;
  localparam int unsigned STATUS_OUT_OVF   = 2;

  // Bus FSM: IDLE accepts a request, RESP holds the response until taken
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/tile_host_bridge_if.sv
// Request/response bus between the host interconnect and the tile bridge.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata (request channel),
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err (response channel).
// master = host side, slave = bridge side.
interface tile_host_bridge_if #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [REG_WIDTH-1:0]  req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [REG_WIDTH-1:0]  rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/tile_host_bridge_regs.sv
// Register file of the tile bridge: operands A/B, CSR_IN, captured DATA_C/CSR_OUT,
// the IN_PEND / OUT_VALID / OUT_OVF handshake flags and the combinational read mux.
// Latency: writes visible on tile outputs the cycle after the accept edge; read mux
// is combinational (registered by the top). No backpressure: capture is unconditional.
// Ports: acc_wr/acc_rd (accepted bus op), addr, wdata, rdata/err (read mux),
//        tile_* (tile operands, result capture, handshake pulses), irq (optional).
// Optional feature macro: TILE_HOST_BRIDGE_IRQ_EN adds IRQ_EN (addr 6) and irq.
module tile_host_bridge_regs
  import tile_host_bridge_pkg::*;
#(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  output logic                     irq,
`endif
  input  logic                     acc_wr,
  input  logic                     acc_rd,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [REG_WIDTH-1:0]     wdata,
  output logic [REG_WIDTH-1:0]     rdata,
  output logic                     err,
  output logic [REG_WIDTH-1:0]     tile_data_a,
  output logic [REG_WIDTH-1:0]     tile_data_b,
  output logic [CSR_IN_WIDTH-1:0]  tile_csr_in,
  input  logic [REG_WIDTH-1:0]     tile_data_c,
  input  logic [CSR_OUT_WIDTH-1:0] tile_csr_out,
  input  logic                     tile_csr_in_re,
  input  logic                     tile_csr_out_we
);

  localparam logic [ADDR_WIDTH-1:0] A_DATA_A  = ADDR_WIDTH'(ADDR_DATA_A);
  localparam logic [ADDR_WIDTH-1:0] A_DATA_B  = ADDR_WIDTH'(ADDR_DATA_B);
  localparam logic [ADDR_WIDTH-1:0] A_CSR_IN  = ADDR_WIDTH'(ADDR_CSR_IN);
  localparam logic [ADDR_WIDTH-1:0] A_DATA_C  = ADDR_WIDTH'(ADDR_DATA_C);
  localparam logic [ADDR_WIDTH-1:0] A_CSR_OUT = ADDR_WIDTH'(ADDR_CSR_OUT);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(ADDR_STATUS);
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN  = ADDR_WIDTH'(ADDR_IRQ_EN);
`endif

  logic [REG_WIDTH-1:0]     data_a_q,   data_a_d;
  logic [REG_WIDTH-1:0]     data_b_q,   data_b_d;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q,   csr_in_d;
  logic [REG_WIDTH-1:0]     data_c_q,   data_c_d;
  logic [CSR_OUT_WIDTH-1:0] csr_out_q,  csr_out_d;
  logic                     in_pend_q,  in_pend_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_ovf_q,  out_ovf_d;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  logic                     irq_en_q,   irq_en_d;
  logic                     irq_q,      irq_d;
`endif

  logic                     rd_csr_out;
  logic [REG_WIDTH-1:0]     status_word;

  assign rd_csr_out = acc_rd && (addr == A_CSR_OUT);

  always_comb begin
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    csr_in_d    = csr_in_q;
    data_c_d    = data_c_q;
    csr_out_d   = csr_out_q;
    in_pend_d   = in_pend_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
    irq_en_d    = irq_en_q;
    // Registered from the current flag, so irq trails OUT_VALID by one cycle
    irq_d       = irq_en_q & out_valid_q;
`endif

    if (acc_wr && addr == A_DATA_A) data_a_d = wdata;
    if (acc_wr && addr == A_DATA_B) data_b_d = wdata;
    if (acc_wr && addr == A_CSR_IN) csr_in_d = wdata[CSR_IN_WIDTH-1:0];
`ifdef TILE_HOST_BRIDGE_IRQ_EN
    if (acc_wr && addr == A_IRQ_EN) irq_en_d = wdata[0];
`endif

    // A fresh CSR_IN write keeps the value pending even if the tile consumes
    // the previous one on the same edge.
    if (acc_wr && addr == A_CSR_IN) in_pend_d = 1'b1;
    else if (tile_csr_in_re)        in_pend_d = 1'b0;

    if (tile_csr_out_we) begin
      data_c_d  = tile_data_c;
      csr_out_d = tile_csr_out;
    end

    // A CSR_OUT read on the capture edge consumes the old result, so the new
    // one is not an overflow; overflow beats a W1C on the same edge.
    if (tile_csr_out_we && out_valid_q && !rd_csr_out)
      out_ovf_d = 1'b1;
    else if (acc_wr && addr == A_STATUS && wdata[STATUS_OUT_OVF])
      out_ovf_d = 1'b0;

    if (tile_csr_out_we) out_valid_d = 1'b1;
    else if (rd_csr_out) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q    <= '0;
      data_b_q    <= '0;
      csr_in_q    <= '0;
      data_c_q    <= '0;
      csr_out_q   <= '0;
      in_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      csr_in_q    <= csr_in_d;
      data_c_q    <= data_c_d;
      csr_out_q   <= csr_out_d;
      in_pend_q   <= in_pend_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
`endif
    end
  end

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_IN_PEND]   = in_pend_q;
    status_word[STATUS_OUT_VALID] = out_valid_q;
    status_word[STATUS_OUT_OVF]   = out_ovf_q;
  end

  // Read mux; err flags unmapped addresses for both reads and writes
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (addr)
      A_DATA_A:  rdata = data_a_q;
      A_DATA_B:  rdata = data_b_q;
      A_CSR_IN:  rdata = REG_WIDTH'(csr_in_q);
      A_DATA_C:  rdata = data_c_q;
      A_CSR_OUT: rdata = REG_WIDTH'(csr_out_q);
      A_STATUS:  rdata = status_word;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
      A_IRQ_EN:  rdata = REG_WIDTH'(irq_en_q);
`endif
      default:   err   = 1'b1;
    endcase
  end

  assign tile_data_a = data_a_q;
  assign tile_data_b = data_b_q;
  assign tile_csr_in = csr_in_q;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  assign irq         = irq_q;
`endif

endmodule

// File: rtl/tile_host_bridge.sv
// Host register bridge for one IP tile slot: bus FSM + registered response,
// register file in tile_host_bridge_regs.
// Latency: 2 cycles minimum per transaction (accept, then response); response
// is held stable while rsp_ready=0 and no new request is accepted until taken.
// Ports: clk, rst (sync, active-high), bus (tile_host_bridge_if.slave),
//        tile_data_a/b, tile_csr_in (to tile), tile_data_c, tile_csr_out,
//        tile_csr_in_re, tile_csr_out_we (from tile), irq (optional).
// Optional feature macro: TILE_HOST_BRIDGE_IRQ_EN adds irq and IRQ_EN register.
module tile_host_bridge
  import tile_host_bridge_pkg::*;
#(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  output logic                     irq,
`endif
  tile_host_bridge_if.slave        bus,
  output logic [REG_WIDTH-1:0]     tile_data_a,
  output logic [REG_WIDTH-1:0]     tile_data_b,
  output logic [CSR_IN_WIDTH-1:0]  tile_csr_in,
  input  logic [REG_WIDTH-1:0]     tile_data_c,
  input  logic [CSR_OUT_WIDTH-1:0] tile_csr_out,
  input  logic                     tile_csr_in_re,
  input  logic                     tile_csr_out_we
);

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 accept;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 rd_err;

  assign accept = bus.req_valid && (state_q == IDLE);

  // State register (also holds the response registers)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response capture: sampled only on the accept edge, then frozen in RESP
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_rdata_d = bus.req_we ? '0 : rd_data;
      rsp_err_d   = rd_err;
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rsp_rdata_q;
    bus.rsp_err   = rsp_err_q;
  end

  tile_host_bridge_regs #(
    .REG_WIDTH    (REG_WIDTH),
    .CSR_IN_WIDTH (CSR_IN_WIDTH),
    .CSR_OUT_WIDTH(CSR_OUT_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_regs (
    .clk            (clk),
    .rst            (rst),
`ifdef TILE_HOST_BRIDGE_IRQ_EN
    .irq            (irq),
`endif
    .acc_wr         (accept && bus.req_we),
    .acc_rd         (accept && !bus.req_we),
    .addr           (bus.req_addr),
    .wdata          (bus.req_wdata),
    .rdata          (rd_data),
    .err            (rd_err),
    .tile_data_a    (tile_data_a),
    .tile_data_b    (tile_data_b),
    .tile_csr_in    (tile_csr_in),
    .tile_data_c    (tile_data_c),
    .tile_csr_out   (tile_csr_out),
    .tile_csr_in_re (tile_csr_in_re),
    .tile_csr_out_we(tile_csr_out_we)
  );

endmodule

// File: tb/tb_tile_host_bridge.sv
// Self-checking bench for tile_host_bridge: directed vector table, hand-written
// sequences for handshake/overflow/backpressure/reset corners, then randomized
// traffic checked against a register-map level reference model.
module tb_tile_host_bridge;

`ifdef TILE_HOST_BRIDGE_IRQ_EN
  localparam logic IRQ_MAPPED = 1'b1;
`else
  localparam logic IRQ_MAPPED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tile_data_a, tile_data_b, tile_data_c;
  logic [15:0] tile_csr_in, tile_csr_out;
  logic        tile_csr_in_re, tile_csr_out_we;
`ifdef TILE_HOST_BRIDGE_IRQ_EN
  logic        irq;
`endif

  tile_host_bridge_if #(.REG_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  tile_host_bridge dut (
    .clk            (clk),
    .rst            (rst),
`ifdef TILE_HOST_BRIDGE_IRQ_EN
    .irq            (irq),
`endif
    .bus            (bus),
    .tile_data_a    (tile_data_a),
    .tile_data_b    (tile_data_b),
    .tile_csr_in    (tile_csr_in),
    .tile_data_c    (tile_data_c),
    .tile_csr_out   (tile_csr_out),
    .tile_csr_in_re (tile_csr_in_re),
    .tile_csr_out_we(tile_csr_out_we)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Tile outputs sampled just after the accept edge of the last transaction
  logic [31:0] acc_a, acc_b;
  logic [15:0] acc_csr;

  // One full bus transaction with optional tile pulses on the accept edge.
  // Entry and exit are 1 time unit after a rising edge.
  task automatic bus_txn(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                         input logic re, input logic owe, input logic [31:0] c,
                         input logic [15:0] co, output logic [31:0] rd, output logic err);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) bound_fail("req_ready_wait");
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    tile_csr_in_re = re; tile_csr_out_we = owe; tile_data_c = c; tile_csr_out = co;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; tile_csr_in_re = 1'b0; tile_csr_out_we = 1'b0;
    acc_a = tile_data_a; acc_b = tile_data_b; acc_csr = tile_csr_in;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) bound_fail("rsp_valid_wait");
    rd = bus.rsp_rdata; err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic tile_pulse(input logic re, input logic owe, input logic [31:0] c,
                            input logic [15:0] co);
    tile_csr_in_re = re; tile_csr_out_we = owe; tile_data_c = c; tile_csr_out = co;
    @(posedge clk); #1;
    tile_csr_in_re = 1'b0; tile_csr_out_we = 1'b0;
  endtask

  // Shorthands for plain reads/writes
  logic [31:0] g_rd;
  logic        g_err;
  task automatic rd_chk(input string nm, input logic [3:0] addr, input logic [31:0] exp);
    bus_txn(1'b0, addr, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0, g_rd, g_err);
    chk(nm, g_rd, exp);
  endtask
  task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
    bus_txn(1'b1, addr, wd, 1'b0, 1'b0, 32'h0, 16'h0, g_rd, g_err);
  endtask

  // ---------------- reference model (register-map level) ----------------
  logic [31:0] m_a, m_b, m_c;
  logic [15:0] m_csr, m_co;
  logic        m_pend, m_ovalid, m_ovf, m_irqen;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_csr = 0; m_co = 0;
    m_pend = 0; m_ovalid = 0; m_ovf = 0; m_irqen = 0;
  endtask

  task automatic model_read(input logic [3:0] addr, output logic [31:0] d, output logic e);
    d = 32'h0; e = 1'b0;
    case (addr)
      4'd0: d = m_a;
      4'd1: d = m_b;
      4'd2: d = {16'h0, m_csr};
      4'd3: d = m_c;
      4'd4: d = {16'h0, m_co};
      4'd5: d = {29'h0, m_ovf, m_ovalid, m_pend};
      4'd6: if (IRQ_MAPPED) d = {31'h0, m_irqen}; else e = 1'b1;
      default: e = 1'b1;
    endcase
  endtask

  // Effect of one clock edge carrying an (optional) accepted op plus tile pulses
  task automatic model_edge(input logic acc, input logic we, input logic [3:0] addr,
                            input logic [31:0] wd, input logic re, input logic owe,
                            input logic [31:0] c, input logic [15:0] co);
    logic rd_co, w_csr, w1c, n_pend, n_ovf, n_ov;
    rd_co  = acc && !we && addr == 4'd4;
    w_csr  = acc && we && addr == 4'd2;
    w1c    = acc && we && addr == 4'd5 && wd[2];
    n_pend = w_csr ? 1'b1 : (re ? 1'b0 : m_pend);
    n_ovf  = (owe && m_ovalid && !rd_co) ? 1'b1 : (w1c ? 1'b0 : m_ovf);
    n_ov   = owe ? 1'b1 : (rd_co ? 1'b0 : m_ovalid);
    if (owe) begin m_c = c; m_co = co; end
    if (acc && we) begin
      if (addr == 4'd0) m_a = wd;
      if (addr == 4'd1) m_b = wd;
      if (addr == 4'd2) m_csr = wd[15:0];
      if (addr == 4'd6 && IRQ_MAPPED) m_irqen = wd[0];
    end
    m_pend = n_pend; m_ovf = n_ovf; m_ovalid = n_ov;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[16];

  logic        r_we, r_re, r_owe, e_err;
  logic [3:0]  r_addr;
  logic [31:0] r_wd, r_c, e_rd;
  logic [15:0] r_co;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd0,  32'h0000_0005, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1,  32'h0000_0007, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,         32'h0000_0005, 1'b0};
    vecs[3]  = '{1'b0, 4'd1,  32'h0,         32'h0000_0007, 1'b0};
    vecs[4]  = '{1'b1, 4'd2,  32'hABCD_1234, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'd2,  32'h0,         32'h0000_1234, 1'b0};
    vecs[6]  = '{1'b0, 4'd5,  32'h0,         32'h0000_0001, 1'b0};
    vecs[7]  = '{1'b1, 4'd3,  32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'd3,  32'h0,         32'h0, 1'b0};
    vecs[9]  = '{1'b1, 4'd4,  32'h0000_FFFF, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 4'd4,  32'h0,         32'h0, 1'b0};
    vecs[11] = '{1'b1, 4'd5,  32'h0000_0007, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 4'd5,  32'h0,         32'h0000_0001, 1'b0};
    vecs[13] = '{1'b0, 4'd15, 32'h0,         32'h0, 1'b1};
    vecs[14] = '{1'b1, 4'd9,  32'h0000_0001, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 4'd6,  32'h0,         32'h0, ~IRQ_MAPPED};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 4'h0; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    tile_csr_in_re = 1'b0; tile_csr_out_we = 1'b0; tile_data_c = 32'h0; tile_csr_out = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_tile_a",    tile_data_a, 32'h0);
    chk("rst_tile_b",    tile_data_b, 32'h0);
    chk("rst_tile_csr",  {16'h0, tile_csr_in}, 32'h0);

    // Register map vectors
    for (int i = 0; i < 16; i++) begin
      bus_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b0, 32'h0, 16'h0, g_rd, g_err);
      chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, g_err}, {31'h0, vecs[i].exp_err});
      if (vecs[i].we && vecs[i].addr == 4'd0) chk("vec_tile_a", acc_a, vecs[i].wdata);
      if (vecs[i].we && vecs[i].addr == 4'd1) chk("vec_tile_b", acc_b, vecs[i].wdata);
      if (vecs[i].we && vecs[i].addr == 4'd2) chk("vec_tile_csr", {16'h0, acc_csr}, {16'h0, vecs[i].wdata[15:0]});
    end

    // IN_PEND: consume clears; write + consume on one edge leaves it set
    tile_pulse(1'b1, 1'b0, 32'h0, 16'h0);
    rd_chk("pend_cleared", 4'd5, 32'h0);
    bus_txn(1'b1, 4'd2, 32'h0000_00FF, 1'b1, 1'b0, 32'h0, 16'h0, g_rd, g_err);
    rd_chk("pend_set_wins", 4'd5, 32'h1);
    rd_chk("csr_in_new", 4'd2, 32'h0000_00FF);
    tile_pulse(1'b1, 1'b0, 32'h0, 16'h0);

    // Capture and read-clear of OUT_VALID
    tile_pulse(1'b0, 1'b1, 32'hDEAD_BEEF, 16'h00A5);
    rd_chk("cap_status", 4'd5, 32'h2);
    rd_chk("cap_data_c", 4'd3, 32'hDEAD_BEEF);
    rd_chk("cap_csr_out", 4'd4, 32'h0000_00A5);
    rd_chk("cap_status_clr", 4'd5, 32'h0);

    // Overflow, W1C, read-vs-capture and overflow-vs-W1C races
    tile_pulse(1'b0, 1'b1, 32'h1111_1111, 16'h0001);
    tile_pulse(1'b0, 1'b1, 32'h2222_2222, 16'h0002);
    rd_chk("ovf_status", 4'd5, 32'h6);
    rd_chk("ovf_data_c", 4'd3, 32'h2222_2222);
    wr(4'd5, 32'h4);
    rd_chk("w1c_status", 4'd5, 32'h2);
    bus_txn(1'b0, 4'd4, 32'h0, 1'b0, 1'b1, 32'h3333_3333, 16'h0003, g_rd, g_err);
    chk("race_rd_old", g_rd, 32'h0000_0002);
    rd_chk("race_status", 4'd5, 32'h2);
    rd_chk("race_data_c", 4'd3, 32'h3333_3333);
    tile_pulse(1'b0, 1'b1, 32'h4444_4444, 16'h0004);
    bus_txn(1'b1, 4'd5, 32'h4, 1'b0, 1'b1, 32'h5555_5555, 16'h0005, g_rd, g_err);
    rd_chk("ovf_beats_w1c", 4'd5, 32'h6);
    rd_chk("drain_csr_out", 4'd4, 32'h0000_0005);
    wr(4'd5, 32'h4);
    rd_chk("status_idle", 4'd5, 32'h0);

    // Backpressure: response held while rsp_ready=0
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'h5);
      chk("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hold_done_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("hold_done_ready", {31'h0, bus.req_ready}, 32'h1);

`ifdef TILE_HOST_BRIDGE_IRQ_EN
    wr(4'd6, 32'h1);
    rd_chk("irq_en_rd", 4'd6, 32'h1);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    tile_pulse(1'b0, 1'b1, 32'h6666_6666, 16'h0006);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_chk("irq_csr_out", 4'd4, 32'h0000_0006);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
`endif

    // Reset while a response is pending
    wr(4'd2, 32'h0000_0042);
    tile_pulse(1'b0, 1'b1, 32'h7777_7777, 16'h0007);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre_rst_valid", {31'h0, bus.rsp_valid}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    chk("mid_rst_tile_a", tile_data_a, 32'h0);
    chk("mid_rst_tile_b", tile_data_b, 32'h0);
    chk("mid_rst_tile_csr", {16'h0, tile_csr_in}, 32'h0);
`ifdef TILE_HOST_BRIDGE_IRQ_EN
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
`endif
    rd_chk("mid_rst_status", 4'd5, 32'h0);
    rd_chk("mid_rst_data_c", 4'd3, 32'h0);

    // Randomized traffic against the reference model
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r_addr = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) r_addr = 4'($urandom_range(8, 15));
      r_we  = 1'($urandom_range(0, 1));
      r_wd  = $urandom;
      r_re  = ($urandom_range(0, 3) == 0);
      r_owe = ($urandom_range(0, 3) == 0);
      r_c   = $urandom;
      r_co  = 16'($urandom);
      model_read(r_addr, e_rd, e_err);
      if (r_we) e_rd = 32'h0;
      bus_txn(r_we, r_addr, r_wd, r_re, r_owe, r_c, r_co, g_rd, g_err);
      chk("rnd_rdata", g_rd, e_rd);
      chk("rnd_err", {31'h0, g_err}, {31'h0, e_err});
      model_edge(1'b1, r_we, r_addr, r_wd, r_re, r_owe, r_c, r_co);
      chk("rnd_tile_a", tile_data_a, m_a);
      chk("rnd_tile_b", tile_data_b, m_b);
      chk("rnd_tile_csr", {16'h0, tile_csr_in}, {16'h0, m_csr});
      if ($urandom_range(0, 2) == 0) begin
        r_re  = 1'($urandom_range(0, 1));
        r_owe = 1'($urandom_range(0, 1));
        r_c   = $urandom;
        r_co  = 16'($urandom);
        tile_pulse(r_re, r_owe, r_c, r_co);
        model_edge(1'b0, 1'b0, 4'd0, 32'h0, r_re, r_owe, r_c, r_co);
      end
    end
    model_read(4'd5, e_rd, e_err);
    rd_chk("rnd_final_status", 4'd5, e_rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
